onfi_sdr_cycle_engine: RTL

// Parametrised ONFI SDR bus-cycle engine; successor of the single-target PHY sequencer.

---
 rtl/onfi_sdr_cycle_engine.sv | 123 ++++++++++++
 1 files changed

// File: rtl/onfi_sdr_cycle_engine.sv
// onfi_sdr_cycle_engine: ONFI SDR bus-cycle engine, one CMD/ADDR/WRITE/READ cycle per request.
// Ports: clk/rst_n; req_* request handshake and fields; cfg_* phase widths (0 acts as 1);
// wp_en -> wp_n; rsp_* one-cycle response; ce_n/cle/ale/we_n/re_n/wp_n/dq_out/dq_oe pads;
// dq_in sampled read data; rb_n asynchronous ready/busy per target.
module onfi_sdr_cycle_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N_TARGETS  = 1,
  parameter int TGT_W      = 1,
  parameter int RB_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [TGT_W-1:0]      req_target,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_wait_rb,
  input  logic                  req_last,
  input  logic [7:0]            cfg_setup,
  input  logic [7:0]            cfg_pulse,
  input  logic [7:0]            cfg_hold,
  input  logic [7:0]            cfg_twb,
  input  logic                  wp_en,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic [N_TARGETS-1:0]  ce_n,
  output logic                  cle,
  output logic                  ale,
  output logic                  we_n,
  output logic                  re_n,
  output logic                  wp_n,
  output logic [DATA_WIDTH-1:0] dq_out,
  output logic                  dq_oe,
  input  logic [DATA_WIDTH-1:0] dq_in,
  input  logic [N_TARGETS-1:0]  rb_n
);
  localparam int CW = ($clog2(RB_TIMEOUT + 1) > 8) ? $clog2(RB_TIMEOUT + 1) : 8;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WB, WAIT_RB, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] typ;
  logic [TGT_W-1:0] tgt;
  logic [DATA_WIDTH-1:0] dat, cap;
  logic [7:0] s_q, p_q, h_q, w_q, dur;
  logic [N_TARGETS-1:0] rb_m, rb_s, mask;
  logic wt, lst, to_q, to_n, fin, rdy, tmo, act, drv;
  assign req_ready = state == IDLE;
  // Out-of-range targets shift the one-hot off the top, leaving no CE asserted.
  assign mask = N_TARGETS'(1) << tgt;
  assign dur = state == SETUP ? s_q : state == PULSE ? p_q : state == HOLD ? h_q : w_q;
  assign fin = cnt == CW'(dur - 8'd1);
  assign rdy = |(rb_s & mask);
  assign tmo = cnt == CW'(RB_TIMEOUT - 1);
  assign act = state == SETUP || state == PULSE || state == HOLD;
  assign drv = act && typ != 2'd3;
  always_comb begin
    nxt = state;
    cnt_n = cnt + 1'b1;
    to_n = to_q;
    case (state)
      IDLE: begin
        cnt_n = '0;
        to_n = 1'b0;
        if (req_valid) nxt = SETUP;
      end
      SETUP: if (fin) begin nxt = PULSE; cnt_n = '0; end
      PULSE: if (fin) begin nxt = HOLD; cnt_n = '0; end
      HOLD: if (fin) begin nxt = wt ? WB : RESP; cnt_n = '0; end
      WB: if (fin) begin nxt = WAIT_RB; cnt_n = '0; end
      WAIT_RB: if (rdy || tmo) begin nxt = RESP; cnt_n = '0; to_n = !rdy; end
      default: begin nxt = IDLE; cnt_n = '0; end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      to_q <= 1'b0;
      {typ, tgt, dat, wt} <= '0;
      lst <= 1'b1;
      {s_q, p_q, h_q, w_q} <= {4{8'd1}};
      cap <= '0;
      {rb_s, rb_m} <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      to_q <= to_n;
      {rb_s, rb_m} <= {rb_m, rb_n};
      if (req_valid && req_ready) begin
        {typ, tgt, dat, wt, lst} <= {req_type, req_target, req_data, req_wait_rb, req_last};
        s_q <= cfg_setup == 8'd0 ? 8'd1 : cfg_setup;
        p_q <= cfg_pulse == 8'd0 ? 8'd1 : cfg_pulse;
        h_q <= cfg_hold == 8'd0 ? 8'd1 : cfg_hold;
        w_q <= cfg_twb == 8'd0 ? 8'd1 : cfg_twb;
      end
      // re_n still low while the FSM has left PULSE marks the re_n rising edge.
      if (!re_n && state != PULSE) cap <= dq_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n <= '1;
      {cle, ale, dq_oe, wp_n, rsp_valid, rsp_timeout} <= '0;
      {we_n, re_n} <= 2'b11;
      dq_out <= '0;
      rsp_data <= '0;
    end else begin
      ce_n <= (state == IDLE && lst) ? '1 : ~mask;
      cle <= act && typ == 2'd0;
      ale <= act && typ == 2'd1;
      we_n <= !(state == PULSE && typ != 2'd3);
      re_n <= !(state == PULSE && typ == 2'd3);
      dq_oe <= drv;
      dq_out <= drv ? dat : '0;
      if (state == IDLE) wp_n <= ~wp_en;
      rsp_valid <= state == RESP;
      rsp_data <= (state == RESP && typ == 2'd3) ? cap : '0;
      rsp_timeout <= state == RESP && to_q;
    end
  end
endmodule
